// File: rtl/tube_scroller.sv
// tube_scroller: horizontally scrolling obstacle ("tube") generator.
// Each of N_TUBES channels carries an 11-bit left-edge position px and an 8-bit
// opening offset gap. While running, every tick moves all tubes left by
// `speed` pixels; a tube that would move past column 0 is recycled one full
// pitch (N_TUBES*SPACING) to the right and gets a fresh opening from the LFSR.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   tick                   one-cycle frame strobe, one motion step per pulse
//   start, stop, clear     one-cycle commands (priority clear > stop > start)
//   speed[2:0]             pixels moved per tick
//   tube_x1/x2/y1/y2       per-tube rectangle, channel i in bits [10i+9:10i]
//   tube_en                per-tube visible flag
//   spawn, pass            one-cycle event pulses (recycle / bird passed)
//   state[1:0]             00 IDLE, 01 RUN, 10 PAUSE
//
// state | meaning
// IDLE  | tubes parked at their start layout, nothing drawn
// RUN   | tubes move on every tick
// PAUSE | positions frozen, drawing continues
module tube_scroller #(
    parameter int         N_TUBES   = 3,
    parameter int         SCR_W     = 800,
    parameter int         TUBE_W    = 100,
    parameter int         GAP_H     = 100,
    parameter int         SPACING   = 300,
    parameter int         BIRD_X    = 200,
    parameter int         Y_MIN     = 40,
    parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic [2:0]              speed,
    output logic [10*N_TUBES-1:0]   tube_x1,
    output logic [10*N_TUBES-1:0]   tube_x2,
    output logic [10*N_TUBES-1:0]   tube_y1,
    output logic [10*N_TUBES-1:0]   tube_y2,
    output logic [N_TUBES-1:0]      tube_en,
    output logic                    spawn,
    output logic                    pass,
    output logic [1:0]              state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam logic [10:0] PITCH   = 11'(N_TUBES * SPACING);
    localparam logic [10:0] LAST_X  = 11'(SCR_W - 1);
    localparam logic [11:0] LAST_12 = 12'(SCR_W - 1);
    localparam logic [11:0] TW_12   = 12'(TUBE_W);
    localparam logic [11:0] BX_12   = 12'(BIRD_X);
    localparam logic [9:0]  YMIN_10 = 10'(Y_MIN);
    localparam logic [9:0]  GAPH_10 = 10'(GAP_H);

    function automatic logic [10:0] home(input int i);
        return 11'(SCR_W + i * SPACING);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << (n % 8);
        return d[15:8];
    endfunction

    state_t               st, st_nxt;
    logic [10:0]          px      [N_TUBES];
    logic [10:0]          px_nxt  [N_TUBES];
    logic [7:0]           gap     [N_TUBES];
    logic [7:0]           gap_nxt [N_TUBES];
    logic [9:0]           lfsr;
    logic                 move;
    logic                 spawn_nxt, pass_nxt;
    logic [11:0]          edge_old, edge_new;
    logic [9:0]           y1_tmp;
    logic [N_TUBES-1:0]   en_nxt;
    logic [10*N_TUBES-1:0] x1_nxt, x2_nxt, y1_nxt, y2_nxt;

    always_comb begin
        st_nxt    = st;
        move      = 1'b0;
        spawn_nxt = 1'b0;
        pass_nxt  = 1'b0;
        edge_old  = '0;
        edge_new  = '0;
        y1_tmp    = '0;
        en_nxt    = '0;
        x1_nxt    = '0;
        x2_nxt    = '0;
        y1_nxt    = '0;
        y2_nxt    = '0;
        for (int i = 0; i < N_TUBES; i++) begin
            px_nxt[i]  = px[i];
            gap_nxt[i] = gap[i];
        end

        if (clear) begin
            st_nxt = IDLE;
            for (int i = 0; i < N_TUBES; i++) px_nxt[i] = home(i);
        end else begin
            case (st)
                RUN: begin
                    // A leaving command wins over a simultaneous tick.
                    if (stop) st_nxt = PAUSE;
                    else      move   = tick;
                end
                PAUSE: if (start) st_nxt = RUN;
                default: begin
                    if (start) begin
                        st_nxt = RUN;
                        for (int i = 0; i < N_TUBES; i++) begin
                            px_nxt[i]  = home(i);
                            gap_nxt[i] = rotl8(lfsr[7:0], i);
                        end
                    end
                end
            endcase
        end

        if (move) begin
            for (int i = 0; i < N_TUBES; i++) begin
                if (px[i] < {8'b0, speed}) begin
                    // 11-bit wraparound of px-speed is undone by adding the pitch.
                    px_nxt[i]  = px[i] - {8'b0, speed} + PITCH;
                    gap_nxt[i] = lfsr[7:0];
                    spawn_nxt  = 1'b1;
                end else begin
                    px_nxt[i] = px[i] - {8'b0, speed};
                    edge_old  = {1'b0, px[i]} + TW_12;
                    edge_new  = {1'b0, px_nxt[i]} + TW_12;
                    if (edge_old >= BX_12 && edge_new < BX_12) pass_nxt = 1'b1;
                end
            end
        end

        // Output image is built from the next-state values so it lands one cycle after the edge.
        for (int i = 0; i < N_TUBES; i++) begin
            if (st_nxt != IDLE && px_nxt[i] <= LAST_X) begin
                en_nxt[i]          = 1'b1;
                edge_new           = {1'b0, px_nxt[i]} + TW_12;
                x1_nxt[10*i +: 10] = px_nxt[i][9:0];
                x2_nxt[10*i +: 10] = (edge_new > LAST_12) ? LAST_12[9:0] : edge_new[9:0];
                y1_tmp             = YMIN_10 + {2'b0, gap_nxt[i]};
                y1_nxt[10*i +: 10] = y1_tmp;
                y2_nxt[10*i +: 10] = y1_tmp + GAPH_10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            lfsr    <= LFSR_SEED;
            for (int i = 0; i < N_TUBES; i++) begin
                px[i]  <= home(i);
                gap[i] <= '0;
            end
            tube_x1 <= '0;
            tube_x2 <= '0;
            tube_y1 <= '0;
            tube_y2 <= '0;
            tube_en <= '0;
            spawn   <= 1'b0;
            pass    <= 1'b0;
        end else begin
            st      <= st_nxt;
            lfsr    <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
            for (int i = 0; i < N_TUBES; i++) begin
                px[i]  <= px_nxt[i];
                gap[i] <= gap_nxt[i];
            end
            tube_x1 <= x1_nxt;
            tube_x2 <= x2_nxt;
            tube_y1 <= y1_nxt;
            tube_y2 <= y2_nxt;
            tube_en <= en_nxt;
            spawn   <= spawn_nxt;
            pass    <= pass_nxt;
        end
    end

    assign state = st;

endmodule

// File: tb/tb_tube_scroller.sv
// tb_tube_scroller: directed test of tube_scroller with default parameters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_tube_scroller;

    localparam int N = 3;

    logic            clk, rst_n, tick, start, stop, clear;
    logic [2:0]      speed;
    logic [10*N-1:0] tube_x1, tube_x2, tube_y1, tube_y2;
    logic [N-1:0]    tube_en;
    logic            spawn, pass;
    logic [1:0]      state;

    int checks = 0;
    int errors = 0;

    logic [9:0] m_lfsr;
    logic [7:0] g_start, g_rec;

    tube_scroller dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .speed(speed),
        .tube_x1(tube_x1), .tube_x2(tube_x2), .tube_y1(tube_y1), .tube_y2(tube_y2),
        .tube_en(tube_en), .spawn(spawn), .pass(pass), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: x^10+x^7+1, advances every clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 10'h2A5;
        else        m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    function automatic logic [9:0] x1c(input int i); return tube_x1[10*i +: 10]; endfunction
    function automatic logic [9:0] x2c(input int i); return tube_x2[10*i +: 10]; endfunction
    function automatic logic [9:0] y1c(input int i); return tube_y1[10*i +: 10]; endfunction
    function automatic logic [9:0] y2c(input int i); return tube_y2[10*i +: 10]; endfunction

    function automatic logic [7:0] rot1(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    task automatic ticks(input int n, input logic [2:0] s);
        speed = s;
        repeat (n) begin
            tick = 1'b1;
            @(negedge clk);
        end
        tick = 1'b0;
    endtask

    task automatic cmd(input logic st_, input logic sp_, input logic cl_);
        start = st_; stop = sp_; clear = cl_;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", state); end
        checks++; if (tube_en !== 3'b000) begin errors++; $display("FAIL reset_en got %b want 000", tube_en); end
        checks++; if (tube_x1 !== '0 || tube_x2 !== '0 || tube_y1 !== '0 || tube_y2 !== '0) begin
            errors++; $display("FAIL reset_coords got x1=%h x2=%h y1=%h y2=%h want 0", tube_x1, tube_x2, tube_y1, tube_y2); end
        checks++; if (spawn !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL reset_pulses got spawn=%b pass=%b want 0", spawn, pass); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_run_basic();
        g_start = m_lfsr[7:0];
        cmd(1'b1, 1'b0, 1'b0);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL start_state got %b want 01", state); end
        checks++; if (tube_en !== 3'b000) begin errors++; $display("FAIL start_en got %b want 000", tube_en); end
        ticks(50, 3'd4);
        checks++; if (x1c(0) !== 10'd600) begin errors++; $display("FAIL run50_x1 got %0d want 600", x1c(0)); end
        checks++; if (x2c(0) !== 10'd700) begin errors++; $display("FAIL run50_x2 got %0d want 700", x2c(0)); end
        checks++; if (tube_en !== 3'b001) begin errors++; $display("FAIL run50_en got %b want 001", tube_en); end
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL run50_state got %b want 01", state); end
        checks++; if (y1c(0) !== 10'd40 + {2'b0, g_start}) begin errors++; $display("FAIL run50_y1 got %0d want %0d", y1c(0), 40 + g_start); end
        checks++; if (y2c(0) !== 10'd140 + {2'b0, g_start}) begin errors++; $display("FAIL run50_y2 got %0d want %0d", y2c(0), 140 + g_start); end
    endtask

    task automatic test_recycle();
        ticks(85, 3'd7);
        ticks(1, 3'd2);
        checks++; if (x1c(0) !== 10'd3) begin errors++; $display("FAIL pre_recycle_x1 got %0d want 3", x1c(0)); end
        g_rec = m_lfsr[7:0];
        ticks(1, 3'd4);
        checks++; if (spawn !== 1'b1) begin errors++; $display("FAIL recycle_spawn got %b want 1", spawn); end
        checks++; if (tube_en !== 3'b110) begin errors++; $display("FAIL recycle_en got %b want 110", tube_en); end
        checks++; if (x1c(0) !== 10'd0) begin errors++; $display("FAIL recycle_x1_hidden got %0d want 0", x1c(0)); end
        checks++; if (x1c(1) !== 10'd299) begin errors++; $display("FAIL recycle_x1_ch1 got %0d want 299", x1c(1)); end
        @(negedge clk);
        checks++; if (spawn !== 1'b0) begin errors++; $display("FAIL spawn_width got %b want 0", spawn); end
        ticks(25, 3'd4);
        checks++; if (tube_en !== 3'b111) begin errors++; $display("FAIL reenter_en got %b want 111", tube_en); end
        checks++; if (x1c(0) !== 10'd799 || x2c(0) !== 10'd799) begin
            errors++; $display("FAIL reenter_x got x1=%0d x2=%0d want 799 799", x1c(0), x2c(0)); end
        checks++; if (y1c(0) !== 10'd40 + {2'b0, g_rec}) begin errors++; $display("FAIL recycle_gap got %0d want %0d", y1c(0), 40 + g_rec); end
        checks++; if (y1c(1) !== 10'd40 + {2'b0, rot1(g_start)}) begin
            errors++; $display("FAIL start_gap_rot ch1 got %0d want %0d", y1c(1), 40 + rot1(g_start)); end
        checks++; if (x1c(2) !== 10'd499) begin errors++; $display("FAIL reenter_x1_ch2 got %0d want 499", x1c(2)); end
    endtask

    task automatic test_commands();
        ticks(1, 3'd0);
        checks++; if (x1c(0) !== 10'd799) begin errors++; $display("FAIL speed0 got %0d want 799", x1c(0)); end
        cmd(1'b1, 1'b1, 1'b0);
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL stop_start state got %b want 10", state); end
        ticks(2, 3'd4);
        checks++; if (x1c(0) !== 10'd799 || tube_en !== 3'b111) begin
            errors++; $display("FAIL pause_freeze got x1=%0d en=%b want 799 111", x1c(0), tube_en); end
        cmd(1'b1, 1'b0, 1'b0);
        checks++; if (state !== 2'b01 || x1c(0) !== 10'd799) begin
            errors++; $display("FAIL resume got state=%b x1=%0d want 01 799", state, x1c(0)); end
        ticks(1, 3'd4);
        checks++; if (x1c(0) !== 10'd795) begin errors++; $display("FAIL resume_move got %0d want 795", x1c(0)); end
        cmd(1'b0, 1'b1, 1'b0);
        cmd(1'b1, 1'b0, 1'b1);
        checks++; if (state !== 2'b00 || tube_en !== 3'b000 || x1c(0) !== 10'd0) begin
            errors++; $display("FAIL clear_start got state=%b en=%b x1=%0d want 00 000 0", state, tube_en, x1c(0)); end
        cmd(1'b0, 1'b1, 1'b0);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL stop_in_idle got %b want 00", state); end
    endtask

    task automatic test_clamp_pass();
        cmd(1'b1, 1'b0, 1'b0);
        ticks(10, 3'd5);
        checks++; if (x1c(0) !== 10'd750 || x2c(0) !== 10'd799) begin
            errors++; $display("FAIL clamp750 got x1=%0d x2=%0d want 750 799", x1c(0), x2c(0)); end
        ticks(7, 3'd7);
        ticks(1, 3'd2);
        checks++; if (x1c(0) !== 10'd699 || x2c(0) !== 10'd799) begin
            errors++; $display("FAIL clamp699 got x1=%0d x2=%0d want 699 799", x1c(0), x2c(0)); end
        ticks(1, 3'd1);
        checks++; if (x1c(0) !== 10'd698 || x2c(0) !== 10'd798) begin
            errors++; $display("FAIL clamp698 got x1=%0d x2=%0d want 698 798", x1c(0), x2c(0)); end
        ticks(85, 3'd7);
        ticks(1, 3'd1);
        checks++; if (x1c(0) !== 10'd102 || pass !== 1'b0) begin
            errors++; $display("FAIL pre_pass got x1=%0d pass=%b want 102 0", x1c(0), pass); end
        ticks(1, 3'd3);
        checks++; if (pass !== 1'b1 || x1c(0) !== 10'd99) begin
            errors++; $display("FAIL pass_pulse got pass=%b x1=%0d want 1 99", pass, x1c(0)); end
        checks++; if (spawn !== 1'b0) begin errors++; $display("FAIL pass_no_spawn got %b want 0", spawn); end
        @(negedge clk);
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL pass_width got %b want 0", pass); end
    endtask

    task automatic test_async_reset();
        ticks(3, 3'd4);
        checks++; if (tube_en[0] !== 1'b1 || state !== 2'b01) begin
            errors++; $display("FAIL pre_reset got en=%b state=%b want en0=1 01", tube_en, state); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (state !== 2'b00 || tube_en !== 3'b000) begin
            errors++; $display("FAIL async_reset got state=%b en=%b want 00 000", state, tube_en); end
        checks++; if (tube_x1 !== '0 || tube_y1 !== '0) begin
            errors++; $display("FAIL async_reset_coords got x1=%h y1=%h want 0", tube_x1, tube_y1); end
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (state !== 2'b00 || tube_en !== 3'b000) begin
            errors++; $display("FAIL post_reset got state=%b en=%b want 00 000", state, tube_en); end
        cmd(1'b1, 1'b0, 1'b0);
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL restart got %b want 01", state); end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; speed = 3'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_run_basic();
        test_recycle();
        test_commands();
        test_clamp_pass();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tube_scroller.md
TUBE_SCROLLER -- requirements
Module: tube_scroller

Interface
REQ-001 Parameter N_TUBES, default 3, number of independent tube channels.
REQ-002 Parameter SCR_W, default 800, visible screen width in pixels; last visible column SCR_W-1.
REQ-003 Parameter TUBE_W, default 100, tube width in pixels.
REQ-004 Parameter GAP_H, default 100, vertical opening height in pixels.
REQ-005 Parameter SPACING, default 300, horizontal pitch between tube left edges; N_TUBES*SPACING SHALL be >= SCR_W+TUBE_W.
REQ-006 Parameter BIRD_X, default 200, bird column used for pass detection.
REQ-007 Parameter Y_MIN, default 40, minimum opening top; Y_MIN+255+GAP_H SHALL be <= 479.
REQ-008 Parameter LFSR_SEED, default 10'h2A5, nonzero LFSR reset value.
REQ-009 clk  input  1  system clock; all state changes on rising edge.
REQ-010 rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-011 tick  input  1  one-cycle frame strobe; one motion step per pulse.
REQ-012 start  input  1  one-cycle command: IDLE->RUN (initialise) or PAUSE->RUN (resume).
REQ-013 stop  input  1  one-cycle command: RUN->PAUSE.
REQ-014 clear  input  1  one-cycle command: any state->IDLE.
REQ-015 speed  input  3  pixels moved per tick, 0..7; 0 freezes motion.
REQ-016 tube_x1, tube_x2, tube_y1, tube_y2  output  10*N_TUBES each  per-tube rectangle, channel i in bits [10i+9:10i].
REQ-017 tube_en  output  N_TUBES  channel i rectangle is visible and valid.
REQ-018 spawn  output  1  one-cycle pulse when any channel recycles.
REQ-019 pass  output  1  one-cycle pulse when any tube's right edge crosses BIRD_X.
REQ-020 state  output  2  00 IDLE, 01 RUN, 10 PAUSE.

Function
REQ-021 FSM states IDLE, RUN, PAUSE; command priority clear > stop > start; commands illegal for the current state are ignored.
REQ-022 IDLE->RUN on start: px[i] <= SCR_W + i*SPACING (11-bit unsigned), gap[i] <= current LFSR[7:0] rotated left by i.
REQ-023 PAUSE->RUN on start: positions and gaps retained; start while RUN ignored.
REQ-024 In RUN, on tick: every channel with px[i] >= speed gets px[i] <= px[i]-speed; tick outside RUN ignored.
REQ-025 Recycle: on tick in RUN with px[i] < speed, px[i] <= px[i] - speed + N_TUBES*SPACING (modulo-free, exact pitch kept), gap[i] <= LFSR[7:0]; spawn pulses next cycle.
REQ-026 Pitch guarantee: SPACING > 7 ensures at most one recycle per tick.
REQ-027 LFSR: 10-bit Fibonacci, taps x^10+x^7+1, advances every clock in every state; never all-zero.
REQ-028 Outputs registered: values reflect a tick/command edge on the following cycle (latency 1).
REQ-029 tube_en[i] = 1 iff state != IDLE and px[i] <= SCR_W-1.
REQ-030 tube_x1 = px[i][9:0]; tube_x2 = SCR_W-1 if px[i]+TUBE_W > SCR_W-1, else px[i]+TUBE_W (11-bit compare).
REQ-031 tube_y1 = Y_MIN + gap[i]; tube_y2 = tube_y1 + GAP_H.
REQ-032 Invisible channels (tube_en=0) drive all four coordinates to 0.
REQ-033 pass pulses when, within one tick, px[i]+TUBE_W goes from >= BIRD_X to < BIRD_X for any i; recycle of the same channel does not generate pass.
REQ-034 spawn and pass are single-cycle, may assert together; never asserted outside RUN.
REQ-035 RUN->PAUSE freezes all positions; tube_en keeps last visibility.
REQ-036 clear from any state: tube_en <= 0, spawn/pass <= 0, positions reinitialised per REQ-022 layout, state <= IDLE.

Reset
REQ-037 rst_n low: state=IDLE, px[i]=SCR_W+i*SPACING, gap[i]=0, LFSR=LFSR_SEED, all outputs 0, effective immediately without clk.
REQ-038 Reset asserted mid-RUN aborts motion; first edge after release sees IDLE.

Verification
REQ-039 Reset then start, speed=4, 50 ticks -> ch0 px=600, tube_x1=600, tube_x2=700, tube_en=3'b001, state=01.
REQ-040 px[0]=3, speed=4, tick -> px[0]=899, spawn pulse 1 cycle, ch0 tube_en=0, gap[0]=LFSR[7:0].
REQ-041 px=750 -> tube_x2=799 (clamped); px=699 -> tube_x2=799; px=698 -> tube_x2=798.
REQ-042 px[0]=102, speed=3, tick -> right edge 202->199 crosses BIRD_X=200, pass pulse exactly 1 cycle.
REQ-043 stop+start same cycle in RUN -> PAUSE; clear+start in PAUSE -> IDLE, tube_en=0; start from PAUSE resumes unchanged px.
REQ-044 rst_n pulsed low asynchronously mid-RUN between clk edges -> outputs 0 and state=00 before next edge.
